// File: rtl/saper_pkg.sv
// Shared constants and types for the mine-board setup logic.
package saper_pkg;

   localparam logic [4:0]  DIM_EASY          = 5'd8;
   localparam logic [4:0]  DIM_MEDIUM        = 5'd10;
   localparam logic [4:0]  DIM_HARD          = 5'd16;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      DRAW,
      CHECK,
      WRITE,
      DONE
   } place_state_t;

   function automatic logic dim_legal(input logic [4:0] dim);
      return (dim == DIM_EASY) || (dim == DIM_MEDIUM) || (dim == DIM_HARD);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] o_q
);

   logic [15:0] r_q;
   logic        w_fb;

   assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

   always_ff @(posedge clk) begin
      if (rst) r_q <= SEED;
      else     r_q <= {r_q[14:0], w_fb};
   end

   assign o_q = r_q;

endmodule

// File: rtl/mine_place_ctrl.sv
// Setup sequencer: clears the active board area, then places the requested number of
// mines at pseudo-random cells, skipping duplicates and the safe cell.
module mine_place_ctrl
   import saper_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
   parameter int unsigned MAX_DIM   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic [4:0]                  i_dimension_size,
   input  logic [5:0]                  i_mines,
   input  logic [$clog2(MAX_DIM)-1:0]  i_safe_x,
   input  logic [$clog2(MAX_DIM)-1:0]  i_safe_y,
   output logic [$clog2(MAX_DIM)-1:0]  o_rd_x,
   output logic [$clog2(MAX_DIM)-1:0]  o_rd_y,
   input  logic                        i_rd_data,
   output logic                        o_wr_en,
   output logic [$clog2(MAX_DIM)-1:0]  o_wr_x,
   output logic [$clog2(MAX_DIM)-1:0]  o_wr_y,
   output logic                        o_wr_data,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_cfg_err,
   output logic [5:0]                  o_placed_cnt
);

   localparam int unsigned CW = $clog2(MAX_DIM);

   place_state_t r_state, w_state_nxt;
   logic [15:0]  w_lfsr;
   logic         w_unused_lfsr;
   logic [4:0]   r_dim;
   logic [5:0]   r_mines;
   logic [CW-1:0] r_safe_x, r_safe_y;
   logic [CW-1:0] r_sx, r_sy, r_cx, r_cy;
   logic [5:0]   r_placed;
   logic         r_cfg_err;
   logic [8:0]   w_area;
   logic         w_cfg_bad, w_start_acc;
   logic [4:0]   w_dim_m1;
   logic         w_last_x, w_last_y;
   logic [CW-1:0] w_cand_x, w_cand_y;
   logic         w_cand_ok;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .o_q (w_lfsr)
   );

   assign w_unused_lfsr = ^w_lfsr[15:8];

   // Validation uses the live inputs since config is latched on the same cycle.
   assign w_area    = 9'(i_dimension_size) * 9'(i_dimension_size);
   assign w_cfg_bad = !dim_legal(i_dimension_size)
                    || (9'(i_mines) > (w_area - 9'd1))
                    || (5'(i_safe_x) >= i_dimension_size)
                    || (5'(i_safe_y) >= i_dimension_size);
   assign w_start_acc = i_start && (r_state == IDLE);

   assign w_dim_m1 = r_dim - 5'd1;
   assign w_last_x = (5'(r_sx) == w_dim_m1);
   assign w_last_y = (5'(r_sy) == w_dim_m1);

   assign w_cand_x  = w_lfsr[3:0];
   assign w_cand_y  = w_lfsr[7:4];
   assign w_cand_ok = (5'(w_cand_x) < r_dim) && (5'(w_cand_y) < r_dim)
                    && !((w_cand_x == r_safe_x) && (w_cand_y == r_safe_y));

   always_comb begin
      w_state_nxt = r_state;
      o_rd_x      = '0;
      o_rd_y      = '0;
      o_wr_en     = 1'b0;
      o_wr_x      = '0;
      o_wr_y      = '0;
      o_wr_data   = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start) w_state_nxt = w_cfg_bad ? DONE : CLEAR;
         end
         CLEAR: begin
            o_busy  = 1'b1;
            o_wr_en = 1'b1;
            o_wr_x  = r_sx;
            o_wr_y  = r_sy;
            if (w_last_x && w_last_y) w_state_nxt = (r_mines == 6'd0) ? DONE : DRAW;
         end
         DRAW: begin
            o_busy = 1'b1;
            o_rd_x = w_cand_x;
            o_rd_y = w_cand_y;
            if (w_cand_ok) w_state_nxt = CHECK;
         end
         CHECK: begin
            o_busy      = 1'b1;
            w_state_nxt = i_rd_data ? DRAW : WRITE;
         end
         WRITE: begin
            o_busy      = 1'b1;
            o_wr_en     = 1'b1;
            o_wr_data   = 1'b1;
            o_wr_x      = r_cx;
            o_wr_y      = r_cy;
            w_state_nxt = ((r_placed + 6'd1) == r_mines) ? DONE : DRAW;
         end
         DONE: begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_dim     <= '0;
         r_mines   <= '0;
         r_safe_x  <= '0;
         r_safe_y  <= '0;
         r_sx      <= '0;
         r_sy      <= '0;
         r_cx      <= '0;
         r_cy      <= '0;
         r_placed  <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_acc) begin
            r_dim     <= i_dimension_size;
            r_mines   <= i_mines;
            r_safe_x  <= i_safe_x;
            r_safe_y  <= i_safe_y;
            r_sx      <= '0;
            r_sy      <= '0;
            r_placed  <= '0;
            r_cfg_err <= w_cfg_bad;
         end
         if (r_state == CLEAR) begin
            if (w_last_x) begin
               r_sx <= '0;
               r_sy <= r_sy + 1'b1;
            end else begin
               r_sx <= r_sx + 1'b1;
            end
         end
         if ((r_state == DRAW) && w_cand_ok) begin
            r_cx <= w_cand_x;
            r_cy <= w_cand_y;
         end
         if (r_state == WRITE) r_placed <= r_placed + 6'd1;
      end
   end

   assign o_cfg_err    = r_cfg_err;
   assign o_placed_cnt = r_placed;

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Scoreboard bench for mine_place_ctrl: a 16x16 board model with 1-cycle read latency.
module tb_mine_place_ctrl;
   import saper_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] dim_in = '0;
   logic [5:0] mines_in = '0;
   logic [3:0] sx_in = '0, sy_in = '0;
   logic [3:0] rd_x, rd_y, wr_x, wr_y;
   logic       rd_data = 1'b0;
   logic       wr_en, wr_data, busy, done, cfg_err;
   logic [5:0] placed_cnt;
   logic       fill_req = 1'b0;

   always #5 clk = ~clk;

   mine_place_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (start),
      .i_dimension_size (dim_in),
      .i_mines          (mines_in),
      .i_safe_x         (sx_in),
      .i_safe_y         (sy_in),
      .o_rd_x           (rd_x),
      .o_rd_y           (rd_y),
      .i_rd_data        (rd_data),
      .o_wr_en          (wr_en),
      .o_wr_x           (wr_x),
      .o_wr_y           (wr_y),
      .o_wr_data        (wr_data),
      .o_busy           (busy),
      .o_done           (done),
      .o_cfg_err        (cfg_err),
      .o_placed_cnt     (placed_cnt)
   );

   logic board [16][16];

   always @(posedge clk) begin
      if (fill_req) begin
         for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) board[y][x] <= 1'b1;
      end else if (wr_en) begin
         board[wr_y][wr_x] <= wr_data;
      end
      rd_data <= board[rd_y][rd_x];
   end

   typedef struct {
      int err;
      int placed;
      int clears;
      int mine_wr;
      int pop;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cur_dim = 0, cur_sx = 0, cur_sy = 0;
   int   run_clears = 0, run_mines = 0;

   function automatic void chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Monitor: per-write legality, and on each done pulse the run totals vs. the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         run_clears = 0;
         run_mines  = 0;
      end else begin
         if (wr_en) begin
            chk("wr_busy", int'(busy), 1);
            chk("wr_in_range", int'((int'(wr_x) < cur_dim) && (int'(wr_y) < cur_dim)), 1);
            if (wr_data) begin
               run_mines++;
               chk("mine_dup", int'(board[wr_y][wr_x]), 0);
               chk("mine_safe", int'((int'(wr_x) == cur_sx) && (int'(wr_y) == cur_sy)), 0);
            end else begin
               run_clears++;
            end
         end
         if (done) begin
            chk("done_expected", exp_q.size(), 1);
            chk("done_busy", int'(busy), 0);
            if (exp_q.size() > 0) begin
               exp_t e;
               int   pop;
               e = exp_q.pop_front();
               chk("cfg_err", int'(cfg_err), e.err);
               chk("placed_cnt", int'(placed_cnt), e.placed);
               chk("clear_writes", run_clears, e.clears);
               chk("mine_writes", run_mines, e.mine_wr);
               if (e.pop >= 0) begin
                  pop = 0;
                  for (int y = 0; y < cur_dim; y++)
                     for (int x = 0; x < cur_dim; x++) pop += int'(board[y][x]);
                  chk("popcount", pop, e.pop);
               end
            end
            run_clears = 0;
            run_mines  = 0;
         end
      end
   end

   // restart_at >= 0 re-pulses start (with a different config) that many cycles in.
   task automatic do_run(input int d, input int m, input int x, input int y,
                         input int err, input int pop, input int restart_at);
      exp_t e;
      bit   seen;
      if (err == 0) begin
         fill_req = 1'b1;
         @(posedge clk);
         #1 fill_req = 1'b0;
      end
      cur_dim = d;
      cur_sx  = x;
      cur_sy  = y;
      e.err     = err;
      e.placed  = err ? 0 : m;
      e.clears  = err ? 0 : d * d;
      e.mine_wr = err ? 0 : m;
      e.pop     = pop;
      exp_q.push_back(e);
      dim_in   = 5'(d);
      mines_in = 6'(m);
      sx_in    = 4'(x);
      sy_in    = 4'(y);
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if (err != 0) chk("err_done_next", int'(done), 1);
            else          chk("start_busy_clr", int'(busy && !cfg_err), 1);
         end
         if (i == restart_at) begin
            start    = 1'b1;
            dim_in   = 5'd16;
            mines_in = 6'd1;
         end
         if (i == restart_at + 1) start = 1'b0;
         if (done) seen = 1'b1;
      end
      chk("done_timeout", int'(seen), 1);
      if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
      repeat (3) @(negedge clk);
      chk("placed_hold", int'(placed_cnt), err ? 0 : m);
      chk("cfg_err_hold", int'(cfg_err), err);
      chk("idle_quiet", int'(busy || wr_en || done), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit reached;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({wr_en, busy, done, cfg_err, placed_cnt, rd_x, rd_y, wr_x, wr_y}), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      do_run(8, 10, 3, 3, 0, 10, -1);
      do_run(16, 40, 0, 0, 0, 40, -1);
      do_run(12, 5, 0, 0, 1, -1, -1);
      do_run(8, 5, 8, 0, 1, -1, -1);
      do_run(16, 3, 15, 15, 0, 3, -1);
      do_run(10, 0, 4, 4, 0, 0, -1);
      do_run(8, 10, 2, 5, 0, 10, 20);

      // Reset mid-placement, then a normal run.
      fill_req = 1'b1;
      @(posedge clk);
      #1 fill_req = 1'b0;
      cur_dim  = 8;
      cur_sx   = 1;
      cur_sy   = 1;
      dim_in   = 5'd8;
      mines_in = 6'd10;
      sx_in    = 4'd1;
      sy_in    = 4'd1;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 20000 && !reached; i++) begin
         @(negedge clk);
         if ((dut.r_state == DRAW) && (placed_cnt >= 6'd3)) reached = 1'b1;
      end
      chk("reach_draw", int'(reached), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outputs", int'({wr_en, busy, done, cfg_err, placed_cnt, rd_x, rd_y, wr_x, wr_y}), 0);
      chk("rst_state_idle", int'(dut.r_state == IDLE), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      do_run(8, 10, 7, 7, 0, 10, -1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
